// File: rtl/rom_read_arbiter.sv
// Two-requester round-robin arbiter in front of a single-cycle-latency ROM.
// One read in flight at a time; the response is held until the consumer takes it.
module rom_read_arbiter #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    output logic                  req1_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_id,
    output logic                  rom_rd_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data
);

    // state | meaning
    // IDLE  | accepting requests, ROM read issued in the granting cycle
    // WAIT  | ROM word arriving, captured into the response register
    // RESP  | response presented, held until rsp_ready
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  gnt_q, gnt_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_id_q, rsp_id_d;
    logic                  any_req;
    logic                  gnt_sel;
    logic                  accept;

    always_comb begin
        any_req = req0_valid | req1_valid;
        // Under contention the requester not served last wins; a lone requester always wins.
        if (req0_valid && req1_valid) begin
            gnt_sel = ~last_grant_q;
        end else begin
            gnt_sel = req1_valid;
        end
        accept     = (state_q == ST_IDLE) && any_req && !rst;
        req0_ready = accept && !gnt_sel;
        req1_ready = accept && gnt_sel;
        rom_rd_en  = accept;
        rom_addr   = accept ? (gnt_sel ? req1_addr : req0_addr) : '0;
        rsp_valid  = (state_q == ST_RESP);
        rsp_data   = rsp_data_q;
        rsp_id     = rsp_id_q;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d      = ST_WAIT;
                    last_grant_d = gnt_sel;
                    gnt_d        = gnt_sel;
                end
            end
            ST_WAIT: begin
                rsp_data_d = rom_data;
                rsp_id_d   = gnt_q;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            rsp_data_q   <= '0;
            rsp_id_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

endmodule
